// File: rtl/sequenciador_instrucoes_pkg.sv
// rtl/sequenciador_instrucoes_pkg.sv - shared types and constants for the instruction sequencer
package sequenciador_instrucoes_pkg;

    localparam int LARGURA_INSTRUCAO = 18;

    localparam logic [1:0] EST_OCIOSO    = 2'd0;
    localparam logic [1:0] EST_PREPARA   = 2'd1;
    localparam logic [1:0] EST_ENVIA     = 2'd2;
    localparam logic [1:0] EST_INTERVALO = 2'd3;

    typedef enum logic [1:0] {
        S_OCIOSO    = EST_OCIOSO,
        S_PREPARA   = EST_PREPARA,
        S_ENVIA     = EST_ENVIA,
        S_INTERVALO = EST_INTERVALO
    } estado_t;

    // Opcode field [17:15], identical to the CPU decoder
    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_STORE   = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_AND     = 3'b100;
    localparam logic [2:0] OP_OR      = 3'b101;
    localparam logic [2:0] OP_JUMP    = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef logic [LARGURA_INSTRUCAO-1:0] instrucao_t;

    function automatic int maximo(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sequenciador_instrucoes_buffer_programa.sv
// rtl/sequenciador_instrucoes_buffer_programa.sv - program store, sync write / async read
module buffer_programa
    import sequenciador_instrucoes_pkg::*;
#(
    parameter int PROFUNDIDADE = 16,
    parameter int LARGURA_END  = $clog2(PROFUNDIDADE)
) (
    input  logic                   clk,
    input  logic                   escrever,
    input  logic [LARGURA_END-1:0] endereco_escrita,
    input  instrucao_t             dado_escrita,
    input  logic [LARGURA_END-1:0] endereco_leitura,
    output instrucao_t             dado_leitura
);

    instrucao_t memoria [PROFUNDIDADE];

    always_ff @(posedge clk) begin
        if (escrever) begin
            memoria[endereco_escrita] <= dado_escrita;
        end
    end

    assign dado_leitura = memoria[endereco_leitura];

endmodule

// File: rtl/sequenciador_instrucoes.sv
// rtl/sequenciador_instrucoes.sv - records instruction words and replays them to the CPU with setup/interval timing
module sequenciador_instrucoes
    import sequenciador_instrucoes_pkg::*;
#(
    parameter int PROFUNDIDADE     = 16,
    parameter int SETUP_CICLOS     = 4,
    parameter int INTERVALO_CICLOS = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [LARGURA_INSTRUCAO-1:0]      instrucao_entrada,
    input  logic                              pulso_gravar,
    input  logic                              pulso_executar,
    input  logic                              pulso_limpar,
    output logic [LARGURA_INSTRUCAO-1:0]      instrucao_completa,
    output logic                              pulso_enviar,
    output logic                              ocupado,
    output logic [$clog2(PROFUNDIDADE):0]     contagem,
    output logic [$clog2(PROFUNDIDADE)-1:0]   indice_atual,
    output logic                              cheio,
    output logic                              vazio
);

    localparam int IW   = $clog2(PROFUNDIDADE);
    localparam int CNTW = IW + 1;
    localparam int CW   = $clog2(maximo(SETUP_CICLOS, INTERVALO_CICLOS)) + 1;

    localparam logic [CW-1:0]   CARGA_PREPARA   = CW'(SETUP_CICLOS - 1);
    localparam logic [CW-1:0]   CARGA_INTERVALO = CW'(INTERVALO_CICLOS - 1);
    localparam logic [CW-1:0]   UM_CONT         = CW'(1);
    localparam logic [CNTW-1:0] UM_CNT          = CNTW'(1);
    localparam logic [IW-1:0]   UM_IDX          = IW'(1);
    localparam logic [CNTW-1:0] CAPACIDADE      = CNTW'(PROFUNDIDADE);

    estado_t          estado, estado_prox;
    logic [CNTW-1:0]  contagem_prox;
    logic [IW-1:0]    indice_prox;
    logic [CW-1:0]    contador, contador_prox;
    instrucao_t       ultima_palavra;
    instrucao_t       dado_lido;
    logic             escrever;
    logic             ultimo_indice;

    buffer_programa #(
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_buffer (
        .clk              (clk),
        .escrever         (escrever),
        .endereco_escrita (contagem[IW-1:0]),
        .dado_escrita     (instrucao_entrada),
        .endereco_leitura (indice_atual),
        .dado_leitura     (dado_lido)
    );

    assign cheio         = (contagem == CAPACIDADE);
    assign vazio         = (contagem == '0);
    assign ultimo_indice = ((CNTW'(indice_atual) + UM_CNT) == contagem);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= S_OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Buffer is frozen while busy, so the read port keeps the presented word stable
    always_ff @(posedge clk) begin
        if (rst) begin
            contagem       <= '0;
            indice_atual   <= '0;
            contador       <= '0;
            ultima_palavra <= '0;
        end else begin
            contagem     <= contagem_prox;
            indice_atual <= indice_prox;
            contador     <= contador_prox;
            if (estado != S_OCIOSO) begin
                ultima_palavra <= dado_lido;
            end
        end
    end

    always_comb begin
        estado_prox        = estado;
        contagem_prox      = contagem;
        indice_prox        = indice_atual;
        contador_prox      = contador;
        escrever           = 1'b0;
        pulso_enviar       = 1'b0;
        ocupado            = 1'b1;
        instrucao_completa = dado_lido;

        case (estado)
            S_OCIOSO: begin
                ocupado            = 1'b0;
                instrucao_completa = ultima_palavra;
                contador_prox      = '0;
                if (pulso_limpar) begin
                    contagem_prox = '0;
                end else if (pulso_executar) begin
                    if (!vazio) begin
                        indice_prox   = '0;
                        contador_prox = CARGA_PREPARA;
                        estado_prox   = S_PREPARA;
                    end
                end else if (pulso_gravar && !cheio) begin
                    escrever      = 1'b1;
                    contagem_prox = contagem + UM_CNT;
                end
            end
            S_PREPARA: begin
                if (contador == '0) begin
                    estado_prox   = S_ENVIA;
                    contador_prox = '0;
                end else begin
                    contador_prox = contador - UM_CONT;
                end
            end
            S_ENVIA: begin
                pulso_enviar  = 1'b1;
                estado_prox   = S_INTERVALO;
                contador_prox = CARGA_INTERVALO;
            end
            S_INTERVALO: begin
                if (contador == '0) begin
                    if (ultimo_indice) begin
                        estado_prox   = S_OCIOSO;
                        contador_prox = '0;
                    end else begin
                        indice_prox   = indice_atual + UM_IDX;
                        estado_prox   = S_PREPARA;
                        contador_prox = CARGA_PREPARA;
                    end
                end else begin
                    contador_prox = contador - UM_CONT;
                end
            end
            default: begin
                estado_prox = S_OCIOSO;
            end
        endcase
    end

endmodule

// File: doc/sequenciador_instrucoes.md
SEQUENCIADOR_INSTRUCOES -- requirements
Module: sequenciador_instrucoes

Interface
REQ-001 Parameter PROFUNDIDADE, default 16: number of 18-bit instruction slots, power of two.
REQ-002 Parameter SETUP_CICLOS, default 4: cycles instrucao_completa is held stable before pulso_enviar.
REQ-003 Parameter INTERVALO_CICLOS, default 1000: cycles after pulso_enviar before the next word is presented.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 instrucao_entrada  input  18  word to record (opcode [17:15], same format the CPU decodes).
REQ-007 pulso_gravar  input  1  one-cycle, already-debounced strobe: append instrucao_entrada.
REQ-008 pulso_executar  input  1  one-cycle strobe: start playback from slot 0.
REQ-009 pulso_limpar  input  1  one-cycle strobe: empty the program buffer.
REQ-010 instrucao_completa  output  18  word presented to the CPU's instruction input.
REQ-011 pulso_enviar  output  1  one-cycle strobe to the CPU's send input.
REQ-012 ocupado  output  1  high while playback is in progress.
REQ-013 contagem  output  clog2(PROFUNDIDADE)+1  number of stored words.
REQ-014 indice_atual  output  clog2(PROFUNDIDADE)  slot currently presented.
REQ-015 cheio, vazio  output  1 each  contagem==PROFUNDIDADE, contagem==0.

Function
REQ-016 The FSM SHALL have states S_OCIOSO, S_PREPARA, S_ENVIA, S_INTERVALO.
REQ-017 In S_OCIOSO, pulso_gravar with cheio=0 SHALL write instrucao_entrada to slot contagem and increment contagem on the same edge.
REQ-018 pulso_gravar with cheio=1 SHALL be ignored; no overwrite, no wrap-around.
REQ-019 In S_OCIOSO, pulso_limpar SHALL set contagem to 0; stored data need not be erased.
REQ-020 In S_OCIOSO, pulso_executar with vazio=0 SHALL set indice_atual=0 and go to S_PREPARA; with vazio=1 it SHALL be ignored.
REQ-021 Priority within one cycle in S_OCIOSO: pulso_limpar > pulso_executar > pulso_gravar; lower-priority strobes that cycle are dropped.
REQ-022 S_PREPARA SHALL drive instrucao_completa = slot[indice_atual] for exactly SETUP_CICLOS cycles, then go to S_ENVIA.
REQ-023 S_ENVIA SHALL last one cycle with pulso_enviar=1 and instrucao_completa unchanged, then go to S_INTERVALO.
REQ-024 S_INTERVALO SHALL hold instrucao_completa for INTERVALO_CICLOS cycles. If indice_atual==contagem-1 it then goes to S_OCIOSO; otherwise it increments indice_atual and goes to S_PREPARA.
REQ-025 ocupado SHALL be 1 in S_PREPARA, S_ENVIA and S_INTERVALO, and 0 in S_OCIOSO.
REQ-026 While ocupado=1, pulso_gravar, pulso_executar and pulso_limpar SHALL be ignored.
REQ-027 In S_OCIOSO, instrucao_completa SHALL hold the last presented word, or 0 if none has been presented since reset.
REQ-028 pulso_enviar SHALL never be high for two consecutive cycles.
REQ-029 A single cycle counter of width clog2(max(SETUP_CICLOS, INTERVALO_CICLOS))+1 SHALL time S_PREPARA and S_INTERVALO and SHALL be reloaded on every state entry.

Reset
REQ-030 rst=1 at a rising edge SHALL force S_OCIOSO and set contagem=0, indice_atual=0, instrucao_completa=0, pulso_enviar=0, ocupado=0, cheio=0, vazio=1, and the cycle counter to 0.
REQ-031 rst mid-playback SHALL abort playback; no pulso_enviar SHALL follow the reset edge.
REQ-032 Buffer RAM contents are not reset.

Structure
REQ-033 A shared package SHALL hold the state encoding localparams, the 3-bit opcode constants (LOAD=000 to DISPLAY=111) and the 18-bit instruction width.
REQ-034 The buffer SHALL be a sub-module buffer_programa: one synchronous write port and an asynchronous read port addressed by indice_atual.

Verification (SETUP_CICLOS=2, INTERVALO_CICLOS=3)
REQ-035 Record 3 words (0x00005, 0x0880A, 0x3FFFF), then pulso_executar -> exactly 3 pulso_enviar strobes 6 cycles apart, carrying those words in order; ocupado falls after the 3rd interval.
REQ-036 Record 17 words -> contagem=16, cheio=1, the 17th word is absent at playback, slot 0 is intact.
REQ-037 pulso_executar with vazio=1 -> ocupado stays 0 and no pulso_enviar occurs.
REQ-038 pulso_gravar during playback -> contagem unchanged, and the played sequence matches the pre-playback buffer.
REQ-039 rst asserted in S_PREPARA of the 2nd word -> on the next cycle all outputs are at reset values; no further pulso_enviar.
REQ-040 pulso_limpar and pulso_gravar in the same cycle -> contagem=0.
